// File: rtl/hdc_bundle_pkg.sv
// Shared definitions for the hypervector bundle sequencer: FSM state
// encoding plus helpers that derive chunk count and index widths.
package hdc_bundle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // Number of K-lane chunks needed to cover d elements (ceiling division).
  function automatic int num_chunks(input int d, input int k);
    return (d + k - 1) / k;
  endfunction

  // Chunk index width; never narrower than one bit.
  function automatic int chunk_w(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

  // Operand count width, wide enough to hold max_ops itself.
  function automatic int op_w(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

endpackage

// File: rtl/bundle_lane_mask.sv
// Combinational chunk-index to lane-mask decoder. Every chunk is fully
// populated except the final one, which may hold only a partial set of lanes.
module bundle_lane_mask
  import hdc_bundle_pkg::*;
#(
  parameter int HYPERVECTOR_DIMENSIONS = 100,
  parameter int NUM_PARALLEL_KERNELS = 1,
  localparam int NUM_CHUNKS = num_chunks(HYPERVECTOR_DIMENSIONS, NUM_PARALLEL_KERNELS),
  localparam int CHUNK_W = chunk_w(NUM_CHUNKS)
) (
  input  logic [CHUNK_W-1:0]              chunk,
  output logic [NUM_PARALLEL_KERNELS-1:0] mask
);

  localparam int LAST_LANES = HYPERVECTOR_DIMENSIONS - (NUM_CHUNKS - 1) * NUM_PARALLEL_KERNELS;

  // All lanes valid, except the low LAST_LANES lanes only on the last chunk.
  always_comb begin
    mask = '1;
    if (chunk == CHUNK_W'(NUM_CHUNKS - 1)) begin
      for (int i = 0; i < NUM_PARALLEL_KERNELS; i++) begin
        mask[i] = (i < LAST_LANES);
      end
    end
  end

endmodule

// File: rtl/bundle_sequencer.sv
// Bundle sequencer: walks every chunk of a hypervector, issuing N-1 addition
// steps per chunk (operand 0 + operand 1, then accumulator + operand 2, ...)
// and writing the chunk result once the last step completes.
//
// Build option: define BUNDLER_OVERFLOW_ABORT_EN to end the job as soon as a
// step reports overflow (no write for that chunk, remaining chunks skipped).
// Without it, overflow only sets the sticky error flag reported with done.
//
// Datapath handshake: dp_valid is a one-cycle launch; the operand indices,
// lane_mask and dp_bundle_loop stay stable until dp_done is sampled in WAIT.
// dp_done/dp_overflow are ignored in any other state.
module bundle_sequencer
  import hdc_bundle_pkg::*;
#(
  parameter int HYPERVECTOR_DIMENSIONS = 100,
  parameter int NUM_PARALLEL_KERNELS = 1,
  parameter int MAX_OPERANDS = 16,
  localparam int NUM_CHUNKS = num_chunks(HYPERVECTOR_DIMENSIONS, NUM_PARALLEL_KERNELS),
  localparam int CHUNK_W = chunk_w(NUM_CHUNKS),
  localparam int OP_W = op_w(MAX_OPERANDS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [OP_W-1:0]                 num_operands,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [CHUNK_W-1:0]              rd_chunk,
  output logic [OP_W-1:0]                 rd_operand,
  output logic [NUM_PARALLEL_KERNELS-1:0] lane_mask,
  output logic                            dp_valid,
  output logic                            dp_bundle_loop,
  input  logic                            dp_done,
  input  logic                            dp_overflow,
  output logic                            wr_en,
  output logic [CHUNK_W-1:0]              wr_chunk
);

`ifdef BUNDLER_OVERFLOW_ABORT_EN
  localparam bit OVERFLOW_ABORT = 1'b1;
`else
  localparam bit OVERFLOW_ABORT = 1'b0;
`endif

  // FSM state is kept as a named enum so checkers can probe it hierarchically.
  state_t                            state;
  logic [OP_W-1:0]                   n_ops;
  logic                              sticky_err;
  logic                              last_chunk;
  logic [CHUNK_W-1:0]                next_chunk;
  logic [NUM_PARALLEL_KERNELS-1:0]   next_mask;

  // Chunk that the next ISSUE will use: 0 on job accept, chunk+1 after a write.
  always_comb begin
    last_chunk = (rd_chunk == CHUNK_W'(NUM_CHUNKS - 1));
    next_chunk = (state == S_WRITE) ? rd_chunk + CHUNK_W'(1) : '0;
  end

  bundle_lane_mask #(
    .HYPERVECTOR_DIMENSIONS (HYPERVECTOR_DIMENSIONS),
    .NUM_PARALLEL_KERNELS   (NUM_PARALLEL_KERNELS)
  ) u_lane_mask (
    .chunk (next_chunk),
    .mask  (next_mask)
  );

  // Sequencer FSM with registered outputs; pulse outputs default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      dp_valid       <= 1'b0;
      dp_bundle_loop <= 1'b0;
      wr_en          <= 1'b0;
      rd_chunk       <= '0;
      rd_operand     <= '0;
      wr_chunk       <= '0;
      lane_mask      <= '1;
      n_ops          <= '0;
      sticky_err     <= 1'b0;
    end else begin
      dp_valid <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_operands >= OP_W'(2) && num_operands <= OP_W'(MAX_OPERANDS)) begin
              state          <= S_ISSUE;
              n_ops          <= num_operands;
              rd_chunk       <= '0;
              rd_operand     <= OP_W'(1);
              lane_mask      <= next_mask;
              dp_bundle_loop <= 1'b0;
              dp_valid       <= 1'b1;
              sticky_err     <= 1'b0;
            end else begin
              // Rejected job: report immediately without touching the datapath.
              state      <= S_DONE;
              done       <= 1'b1;
              error      <= 1'b1;
              sticky_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_done) begin
            sticky_err <= sticky_err | dp_overflow;
            if (OVERFLOW_ABORT && dp_overflow) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (rd_operand < n_ops - OP_W'(1)) begin
              state          <= S_ISSUE;
              rd_operand     <= rd_operand + OP_W'(1);
              dp_bundle_loop <= 1'b1;
              dp_valid       <= 1'b1;
            end else begin
              state    <= S_WRITE;
              wr_en    <= 1'b1;
              wr_chunk <= rd_chunk;
            end
          end
        end
        S_WRITE: begin
          if (last_chunk) begin
            state <= S_DONE;
            done  <= 1'b1;
            error <= sticky_err;
          end else begin
            state          <= S_ISSUE;
            rd_chunk       <= next_chunk;
            rd_operand     <= OP_W'(1);
            lane_mask      <= next_mask;
            dp_bundle_loop <= 1'b0;
            dp_valid       <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Directed bench for bundle_sequencer. u0: D=100, K=8 (13 chunks);
// u1: D=8, K=8 (single chunk). Each DUT has a simple datapath responder
// with programmable latency and an optional overflow on a chosen chunk.
// Expected results honour BUNDLER_OVERFLOW_ABORT_EN when defined.
module tb_bundle_sequencer;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT u0 : D=100 K=8 ----------------
  logic       start0, busy0, done0, error0, dp_valid0, loop0, dp_done0, dp_ovf0, wr_en0;
  logic [4:0] num0, rd_operand0;
  logic [3:0] rd_chunk0, wr_chunk0;
  logic [7:0] lane_mask0;

  bundle_sequencer #(
    .HYPERVECTOR_DIMENSIONS (100),
    .NUM_PARALLEL_KERNELS   (8),
    .MAX_OPERANDS           (16)
  ) u0 (
    .clk            (clk),
    .reset          (reset),
    .start          (start0),
    .num_operands   (num0),
    .busy           (busy0),
    .done           (done0),
    .error          (error0),
    .rd_chunk       (rd_chunk0),
    .rd_operand     (rd_operand0),
    .lane_mask      (lane_mask0),
    .dp_valid       (dp_valid0),
    .dp_bundle_loop (loop0),
    .dp_done        (dp_done0),
    .dp_overflow    (dp_ovf0),
    .wr_en          (wr_en0),
    .wr_chunk       (wr_chunk0)
  );

  // ---------------- DUT u1 : D=8 K=8 ----------------
  logic       start1, busy1, done1, error1, dp_valid1, loop1, dp_done1, dp_ovf1, wr_en1;
  logic [4:0] num1, rd_operand1;
  logic [0:0] rd_chunk1, wr_chunk1;
  logic [7:0] lane_mask1;

  bundle_sequencer #(
    .HYPERVECTOR_DIMENSIONS (8),
    .NUM_PARALLEL_KERNELS   (8),
    .MAX_OPERANDS           (16)
  ) u1 (
    .clk            (clk),
    .reset          (reset),
    .start          (start1),
    .num_operands   (num1),
    .busy           (busy1),
    .done           (done1),
    .error          (error1),
    .rd_chunk       (rd_chunk1),
    .rd_operand     (rd_operand1),
    .lane_mask      (lane_mask1),
    .dp_valid       (dp_valid1),
    .dp_bundle_loop (loop1),
    .dp_done        (dp_done1),
    .dp_overflow    (dp_ovf1),
    .wr_en          (wr_en1),
    .wr_chunk       (wr_chunk1)
  );

  // ---------------- datapath responders ----------------
  // dp_valid seen at negedge -> dp_done presented lat negedges later, so the
  // DUT samples it L clock edges after it sampled dp_valid.
  int lat0 = 1, lat1 = 1, cnt0 = 0, cnt1 = 0, ovf_chunk0 = -1;

  always @(negedge clk) begin
    dp_done0 = 1'b0;
    dp_ovf0  = 1'b0;
    if (cnt0 > 0) begin
      cnt0--;
      if (cnt0 == 0) begin
        dp_done0 = 1'b1;
        dp_ovf0  = (int'(rd_chunk0) == ovf_chunk0);
      end
    end
    if (dp_valid0) cnt0 = lat0;
  end

  always @(negedge clk) begin
    dp_done1 = 1'b0;
    dp_ovf1  = 1'b0;
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) dp_done1 = 1'b1;
    end
    if (dp_valid1) cnt1 = lat1;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] wr_q[$];
  logic [3:0] iss_chunk_q[$];
  logic [4:0] iss_op_q[$];
  logic       iss_loop_q[$];
  logic [7:0] iss_mask_q[$];
  int         obs_lat;
  logic       obs_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Run one job on the selected DUT and record everything it emits until done.
  task automatic run_job(input int sel, input logic [4:0] n, input int budget);
    int  j;
    bit  got;
    logic dv, lp, we, dn, er;
    logic [4:0] op;
    logic [3:0] ck, wc;
    logic [7:0] mk;
    wr_q.delete(); iss_chunk_q.delete(); iss_op_q.delete();
    iss_loop_q.delete(); iss_mask_q.delete();
    obs_lat = -1;
    obs_err = 1'bx;
    @(negedge clk);
    if (sel == 0) begin start0 = 1'b1; num0 = n; end
    else          begin start1 = 1'b1; num1 = n; end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    j = 0;
    got = 0;
    while (!got && j < budget) begin
      if (sel == 0) begin
        dv = dp_valid0; lp = loop0; op = rd_operand0; mk = lane_mask0; ck = rd_chunk0;
        we = wr_en0; wc = wr_chunk0; dn = done0; er = error0;
      end else begin
        dv = dp_valid1; lp = loop1; op = rd_operand1; mk = lane_mask1; ck = {3'b000, rd_chunk1};
        we = wr_en1; wc = {3'b000, wr_chunk1}; dn = done1; er = error1;
      end
      if (dv) begin
        iss_chunk_q.push_back(ck);
        iss_op_q.push_back(op);
        iss_loop_q.push_back(lp);
        iss_mask_q.push_back(mk);
      end
      if (we) wr_q.push_back(wc);
      if (dn) begin
        got = 1;
        obs_lat = j + 1;
        obs_err = er;
      end else begin
        j++;
        @(negedge clk);
      end
    end
    check("done_within_budget", 32'(got), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_wr_chunk"}, 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_u0(input string tag);
    check({tag, "_flags"}, {26'd0, busy0, done0, error0, dp_valid0, loop0, wr_en0}, 32'd0);
    check({tag, "_rd_chunk"}, 32'(rd_chunk0), 32'd0);
    check({tag, "_rd_operand"}, 32'(rd_operand0), 32'd0);
    check({tag, "_wr_chunk"}, 32'(wr_chunk0), 32'd0);
    check({tag, "_lane_mask"}, 32'(lane_mask0), 32'hFF);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stray;
    reset = 1'b1;
    start0 = 1'b0; num0 = '0;
    start1 = 1'b0; num1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_u0("reset_u0");
    check("reset_u1_flags", {26'd0, busy1, done1, error1, dp_valid1, loop1, wr_en1}, 32'd0);
    check("reset_u1_mask", 32'(lane_mask1), 32'hFF);
    reset = 1'b0;

    // N=2, L=1 over 13 chunks: done at t+40, writes 0..12, masks FF.. 0F.
    lat0 = 1;
    run_job(0, 5'd2, 200);
    check("n2_latency", 32'(obs_lat), 32'd40);
    check("n2_error", 32'(obs_err), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 13; i++) exp_q.push_back(4'(i));
    check_writes("n2");
    check("n2_issue_count", 32'(iss_chunk_q.size()), 32'd13);
    for (int i = 0; i < iss_chunk_q.size(); i++) begin
      check("n2_issue_chunk", 32'(iss_chunk_q[i]), 32'(i));
      check("n2_issue_mask", 32'(iss_mask_q[i]), (i == 12) ? 32'h0F : 32'hFF);
      check("n2_issue_op", 32'(iss_op_q[i]), 32'd1);
      check("n2_issue_loop", 32'(iss_loop_q[i]), 32'd0);
    end

    // Rejected operand counts: 0, 1 and above MAX (17).
    run_job(0, 5'd0, 20);
    check("n0_latency", 32'(obs_lat), 32'd1);
    check("n0_error", 32'(obs_err), 32'd1);
    check("n0_no_issue", 32'(iss_chunk_q.size()), 32'd0);
    check("n0_no_write", 32'(wr_q.size()), 32'd0);
    run_job(0, 5'd1, 20);
    check("n1_latency", 32'(obs_lat), 32'd1);
    check("n1_error", 32'(obs_err), 32'd1);
    check("n1_no_issue", 32'(iss_chunk_q.size()), 32'd0);
    check("n1_no_write", 32'(wr_q.size()), 32'd0);
    run_job(0, 5'd17, 20);
    check("n17_latency", 32'(obs_lat), 32'd1);
    check("n17_error", 32'(obs_err), 32'd1);
    check("n17_no_issue", 32'(iss_chunk_q.size()), 32'd0);

    // N=4, L=2, single chunk: loops 0,1,1; operands 1,2,3; done at t+11.
    lat1 = 2;
    run_job(1, 5'd4, 60);
    check("n4_latency", 32'(obs_lat), 32'd11);
    check("n4_error", 32'(obs_err), 32'd0);
    check("n4_issue_count", 32'(iss_op_q.size()), 32'd3);
    for (int i = 0; i < iss_op_q.size(); i++) begin
      check("n4_issue_op", 32'(iss_op_q[i]), 32'(i + 1));
      check("n4_issue_loop", 32'(iss_loop_q[i]), (i == 0) ? 32'd0 : 32'd1);
      check("n4_issue_mask", 32'(iss_mask_q[i]), 32'hFF);
    end
    exp_q.delete();
    exp_q.push_back(4'd0);
    check_writes("n4");

    // N=MAX=16, L=1, single chunk: 15 steps of 2 cycles + write -> t+32.
    lat1 = 1;
    run_job(1, 5'd16, 100);
    check("n16_latency", 32'(obs_lat), 32'd32);
    check("n16_error", 32'(obs_err), 32'd0);
    check("n16_issue_count", 32'(iss_op_q.size()), 32'd15);
    check("n16_last_op", 32'(iss_op_q[iss_op_q.size()-1]), 32'd15);

    // Overflow reported on chunk 3.
    ovf_chunk0 = 3;
    run_job(0, 5'd2, 200);
    check("ovf_error", 32'(obs_err), 32'd1);
    exp_q.delete();
`ifdef BUNDLER_OVERFLOW_ABORT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(4'(i));
    check("ovf_latency", 32'(obs_lat), 32'd12);
`else
    for (int i = 0; i < 13; i++) exp_q.push_back(4'(i));
    check("ovf_latency", 32'(obs_lat), 32'd40);
`endif
    check_writes("ovf");

    // Next accepted job clears the sticky error.
    ovf_chunk0 = -1;
    run_job(0, 5'd2, 200);
    check("sticky_clear_error", 32'(obs_err), 32'd0);
    check("sticky_clear_latency", 32'(obs_lat), 32'd40);

    // Reset in WAIT with a stray start while busy and a late dp_done.
    lat0 = 4;
    @(negedge clk);
    start0 = 1'b1; num0 = 5'd3;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1; num0 = 5'd2;
    check("midjob_busy", 32'(busy0), 32'd1);
    check("midjob_in_wait", 32'(dp_valid0), 32'd0);
    @(negedge clk);
    start0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_u0("midjob_reset");
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0 || wr_en0 || dp_valid0 || busy0) stray++;
    end
    check("post_reset_quiet", 32'(stray), 32'd0);
    check_reset_u0("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
